// File: rtl/arb_mux.sv
// arb_mux: N:1 round-robin arbiter feeding a registered one-word output stage (ARB_MUX_FIXED_PRIO_EN selects fixed lowest-index priority)
module arb_mux #(
    parameter int BIT_WIDTH = 32,
    parameter int NUM_IN = 3,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*BIT_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [BIT_WIDTH-1:0]    out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);
    logic [SEL_W-1:0] grant;
    logic free;
    logic xfer;
`ifndef ARB_MUX_FIXED_PRIO_EN
    logic [SEL_W-1:0] ptr;
`endif
    assign free = !out_valid || out_ready;
    assign xfer = (|in_valid) && free;
`ifdef ARB_MUX_FIXED_PRIO_EN
    // Lowest-index valid channel wins; backwards scan lets the lowest hit overwrite
    always_comb begin
        grant = '0;
        for (int k = NUM_IN - 1; k >= 0; k--)
            if (in_valid[k]) grant = SEL_W'(k);
    end
`else
    // Scan ptr, ptr+1, ... wrapping; backwards scan lets the earliest hit in that order win
    always_comb begin
        grant = '0;
        for (int k = NUM_IN - 1; k >= 0; k--)
            if (in_valid[(int'(ptr) + k) % NUM_IN]) grant = SEL_W'((int'(ptr) + k) % NUM_IN);
    end
`endif
    // Only the granted channel sees ready, and only when the output stage can take a word
    always_comb begin
        in_ready = '0;
        in_ready[grant] = xfer;
    end
    // Output register loads on transfer, drains on downstream accept, holds otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_sel <= '0;
`ifndef ARB_MUX_FIXED_PRIO_EN
            ptr <= '0;
`endif
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data <= in_data[grant*BIT_WIDTH +: BIT_WIDTH];
            out_sel <= grant;
`ifndef ARB_MUX_FIXED_PRIO_EN
            ptr <= (grant == SEL_W'(NUM_IN - 1)) ? '0 : grant + 1'b1;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed self-checking bench for arb_mux with NUM_IN=3, BIT_WIDTH=32
module tb_arb_mux;
    localparam logic [31:0] D0 = 32'hA0A0_0000;
    localparam logic [31:0] D1 = 32'hDEAD_BEEF;
    localparam logic [31:0] D2 = 32'hC2C2_2222;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [95:0] in_data = {D2, D1, D0};
    logic [2:0] in_valid = 3'b000;
    logic [2:0] in_ready;
    logic [31:0] out_data;
    logic [1:0] out_sel;
    logic out_valid;
    logic out_ready = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    arb_mux #(.BIT_WIDTH(32), .NUM_IN(3)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 3'b000;
        out_ready = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_checks++; if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel: got %0d want 0", out_sel); end
        #2 rst = 1'b0;
        n_checks++; if (in_ready !== 3'b000) begin n_fail++; $display("FAIL idle_ready: got %b want 000", in_ready); end
    endtask

    task automatic test_single();
        in_valid = 3'b010;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready: got %b want 010", in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_checks++; if (out_data !== D1) begin n_fail++; $display("FAIL single_data: got %h want %h", out_data, D1); end
        n_checks++; if (out_sel !== 2'd1) begin n_fail++; $display("FAIL single_sel: got %0d want 1", out_sel); end
        in_valid = 3'b000;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel [4];
        logic [31:0] exp_data [4];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp_data = '{D0, D1, D2, D0};
        in_valid = 3'b111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b want 1", i, out_valid); end
            n_checks++; if (out_sel !== exp_sel[i]) begin n_fail++; $display("FAIL rr_sel[%0d]: got %0d want %0d", i, out_sel, exp_sel[i]); end
            n_checks++; if (out_data !== exp_data[i]) begin n_fail++; $display("FAIL rr_data[%0d]: got %h want %h", i, out_data, exp_data[i]); end
        end
        in_valid = 3'b000;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        in_valid = 3'b111;
        out_ready = 1'b0;
        #1;
        n_checks++; if (in_ready !== 3'b010) begin n_fail++; $display("FAIL bp_first_ready: got %b want 010", in_ready); end
        step();
        n_checks++; if (out_sel !== 2'd1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_load: got sel %0d valid %b want sel 1 valid 1", out_sel, out_valid); end
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (in_ready !== 3'b000) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b want 000", i, in_ready); end
            step();
            n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== D1) begin n_fail++; $display("FAIL bp_hold[%0d]: got valid %b sel %0d data %h want 1 1 %h", i, out_valid, out_sel, out_data, D1); end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 3'b100) begin n_fail++; $display("FAIL bp_release_ready: got %b want 100", in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== D2) begin n_fail++; $display("FAIL bp_no_bubble: got valid %b sel %0d data %h want 1 2 %h", out_valid, out_sel, out_data, D2); end
        in_valid = 3'b000;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_wrap();
        in_valid = 3'b101;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 3'b001) begin n_fail++; $display("FAIL wrap_ready0: got %b want 001", in_ready); end
        step();
        n_checks++; if (out_sel !== 2'd0) begin n_fail++; $display("FAIL wrap_sel0: got %0d want 0", out_sel); end
        n_checks++; if (in_ready !== 3'b100) begin n_fail++; $display("FAIL wrap_ready2: got %b want 100", in_ready); end
        step();
        n_checks++; if (out_sel !== 2'd2 || out_data !== D2) begin n_fail++; $display("FAIL wrap_sel2: got sel %0d data %h want 2 %h", out_sel, out_data, D2); end
        in_valid = 3'b000;
        step();
    endtask

    task automatic test_async_reset();
        in_valid = 3'b001;
        out_ready = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== D0) begin n_fail++; $display("FAIL ar_load: got valid %b data %h want 1 %h", out_valid, out_data, D0); end
        in_valid = 3'b000;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 2'd0) begin n_fail++; $display("FAIL ar_clear: got valid %b data %h sel %0d want 0 0 0", out_valid, out_data, out_sel); end
        #1 rst = 1'b0;
        in_valid = 3'b010;
        out_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 3'b010) begin n_fail++; $display("FAIL ar_ready: got %b want 010", in_ready); end
        step();
        n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== D1) begin n_fail++; $display("FAIL ar_first: got valid %b sel %0d data %h want 1 1 %h", out_valid, out_sel, out_data, D1); end
        in_valid = 3'b000;
        step();
    endtask

    task automatic test_fixed_prio();
        in_valid = 3'b111;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++; if (in_ready !== 3'b001) begin n_fail++; $display("FAIL fp_ready[%0d]: got %b want 001", i, in_ready); end
            step();
            n_checks++; if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== D0) begin n_fail++; $display("FAIL fp_out[%0d]: got valid %b sel %0d data %h want 1 0 %h", i, out_valid, out_sel, out_data, D0); end
        end
        in_valid = 3'b000;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef ARB_MUX_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_async_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32: data width per channel.
REQ-002 SHALL have parameter NUM_IN, default 3, legal 2..16: number of input channels.
REQ-003 SHALL derive localparam SEL_W = $clog2(NUM_IN): width of the channel index.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_data, input, NUM_IN*BIT_WIDTH: channel i occupies bits [i*BIT_WIDTH +: BIT_WIDTH].
REQ-007 SHALL have port in_valid, input, NUM_IN: per-channel data-valid.
REQ-008 SHALL have port in_ready, output, NUM_IN: per-channel accept, one-hot or zero.
REQ-009 SHALL have port out_data, output, BIT_WIDTH: registered selected data.
REQ-010 SHALL have port out_sel, output, SEL_W: index of the channel that supplied out_data.
REQ-011 SHALL have port out_valid, output, 1: out_data/out_sel hold a word.
REQ-012 SHALL have port out_ready, input, 1: downstream accept.

Function
REQ-013 SHALL define free = !out_valid || out_ready (combinational).
REQ-014 SHALL arbitrate among asserted in_valid bits: grant = first valid index scanning ptr, ptr+1, ... NUM_IN-1, then 0 .. ptr-1.
REQ-015 SHALL drive in_ready[grant] = free; all other in_ready bits SHALL be 0; in_ready SHALL be all-zero when no in_valid is set.
REQ-016 SHALL define an input transfer as in_valid[i] && in_ready[i]; at most one per cycle.
REQ-017 SHALL on a transfer load out_data <= in_data[grant], out_sel <= grant, out_valid <= 1 at the next edge (latency 1 cycle).
REQ-018 SHALL on a transfer update ptr <= grant+1, wrapping to 0 when grant == NUM_IN-1.
REQ-019 SHALL clear out_valid at the next edge when out_valid && out_ready and no transfer occurs.
REQ-020 SHALL hold out_data, out_sel, out_valid and ptr unchanged when out_valid && !out_ready.
REQ-021 SHALL sustain one word per cycle when out_ready is held high and any in_valid is set (simultaneous drain and load).
REQ-022 SHALL leave ptr unchanged in cycles with no transfer.
REQ-023 SHALL never drop or duplicate a word: each transfer produces exactly one out_valid && out_ready beat.

Reset
REQ-024 SHALL on rst assertion immediately (asynchronously) set out_valid=0, out_data=0, out_sel=0, ptr=0.
REQ-025 SHALL discard any held word when rst asserts mid-operation; in_ready SHALL follow REQ-015 with free=1 after reset release.
REQ-026 SHALL accept the first transfer in the first clock edge after rst deasserts.

Configuration
REQ-027 SHALL honour macro ARB_MUX_FIXED_PRIO_EN: when defined, grant = lowest-index valid channel, ptr absent and REQ-018/022 void; when undefined, round-robin per REQ-014/018.

Verification
REQ-028 SHALL cover: NUM_IN=3, in_valid=3'b010, in_data[1]=32'hDEADBEEF, out_ready=1 -> in_ready=3'b010; next cycle out_valid=1, out_data=32'hDEADBEEF, out_sel=1.
REQ-029 SHALL cover: all three valid, out_ready=1 for 4 cycles from reset -> out_sel sequence 0,1,2,0 on consecutive cycles, out_valid continuously 1.
REQ-030 SHALL cover: out_valid=1, out_ready=0 for 5 cycles -> in_ready=3'b000, out_data/out_sel stable; out_ready=1 -> next word loaded same edge, no bubble.
REQ-031 SHALL cover: last grant 2 (ptr=0), in_valid=3'b101 -> grant 0, then grant 2.
REQ-032 SHALL cover: rst asserted between edges while out_valid=1 -> out_valid=0, out_data=0 before next edge; ch1 valid after release -> out_sel=1.
REQ-033 SHALL cover: ARB_MUX_FIXED_PRIO_EN defined, all valid, out_ready=1 -> out_sel=0 every cycle; in_ready[2:1] never asserted.
